// File: rtl/qed_inst_filter.sv
// Stateful RV32I legality filter for the SQED harness: decodes, classifies and gates
// fetched words, tracks SIF-commit phase and store spacing. Optional macro: QED_FORMAL_ASSUME_EN.
module qed_inst_filter #(
    parameter int REG_LIMIT    = 16,
    parameter int LD_IMM_LIMIT = 64,
    parameter int ST_IMM_LIMIT = 2,
    parameter int STORE_GAP    = 1,
    parameter int PC_DEP_EN    = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic [31:0]      instruction,
    input  logic             sif_commit,
    output logic             inst_legal,
    output logic [3:0]       inst_class,
    output logic             phase,
    output logic             violation,
    output logic [31:0]      bad_inst,
    output logic [CNT_W-1:0] legal_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int GAP_W = (STORE_GAP > 0) ? $clog2(STORE_GAP + 1) : 1;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_I      = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_FENCE  = 4'd9,
        CLS_SYSTEM = 4'd10,
        CLS_NOP    = 4'd11
    } inst_class_e;

    typedef enum logic {
        PRE_COMMIT  = 1'b0,
        POST_COMMIT = 1'b1
    } phase_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_NOP    = 7'b1111111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    phase_e            phase_q, phase_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              violation_q, violation_d;
    logic [31:0]       bad_inst_q, bad_inst_d;
    logic [CNT_W-1:0]  legal_cnt_q, legal_cnt_d;
    logic [CNT_W-1:0]  store_cnt_q, store_cnt_d;

    inst_class_e class_c;
    logic        fields_ok;
    logic        commit_eff;
    logic        store_open;
    logic        accept;
    logic        reject;
    logic        accept_store;

    function automatic logic reg_ok(input logic [4:0] r);
        return ({27'd0, r} < REG_LIMIT);
    endfunction

    // JAL/AUIPC write a PC-derived value; without PC_DEP_EN that value must be discarded.
    function automatic logic pc_rd_ok(input logic [4:0] r);
        if (PC_DEP_EN != 0) begin
            return reg_ok(r);
        end
        return (r == 5'd0);
    endfunction

    always_comb begin
        class_c   = CLS_NONE;
        fields_ok = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    class_c   = CLS_R;
                    fields_ok = reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
                end
            end
            OP_I: begin
                if ((funct3 == 3'b001 && funct7 == F7_ZERO) ||
                    (funct3 == 3'b101 && (funct7 == F7_ZERO || funct7 == F7_ALT)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    class_c   = CLS_I;
                    fields_ok = reg_ok(rd) && reg_ok(rs1);
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                    funct3 == 3'b100 || funct3 == 3'b101) begin
                    class_c   = CLS_LOAD;
                    fields_ok = (rs1 == 5'd0) && (instruction[31:30] == 2'b00) &&
                                ({20'd0, instruction[31:20]} < LD_IMM_LIMIT) && reg_ok(rd);
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    class_c   = CLS_STORE;
                    fields_ok = (rs1 == 5'd0) && (instruction[31:30] == 2'b00) &&
                                ({25'd0, funct7} < ST_IMM_LIMIT) && reg_ok(rs2);
                end
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    class_c   = CLS_BRANCH;
                    fields_ok = reg_ok(rs1) && reg_ok(rs2);
                end
            end
            OP_JAL: begin
                class_c   = CLS_JAL;
                fields_ok = pc_rd_ok(rd);
            end
            OP_LUI: begin
                class_c   = CLS_LUI;
                fields_ok = reg_ok(rd);
            end
            OP_AUIPC: begin
                class_c   = CLS_AUIPC;
                fields_ok = pc_rd_ok(rd);
            end
            OP_FENCE: begin
                if (funct3 == 3'b000) begin
                    class_c   = CLS_FENCE;
                    fields_ok = 1'b1;
                end
            end
            OP_SYSTEM: begin
                // Only ECALL (imm 0) and EBREAK (imm 1) are recognised.
                if (funct3 == 3'b000 && instruction[31:21] == 11'd0) begin
                    class_c   = CLS_SYSTEM;
                    fields_ok = (rs1 == 5'd0) && (rd == 5'd0);
                end
            end
            OP_NOP: begin
                class_c   = CLS_NOP;
                fields_ok = (instruction[31:7] == 25'd0);
            end
            default: begin
                class_c   = CLS_NONE;
                fields_ok = 1'b0;
            end
        endcase
    end

    assign commit_eff   = sif_commit | (phase_q == POST_COMMIT);
    assign store_open   = commit_eff && (gap_q == '0);
    assign inst_legal   = fields_ok && ((class_c != CLS_STORE) || store_open);
    assign inst_class   = class_c;
    assign accept       = inst_valid & inst_legal;
    assign reject       = inst_valid & ~inst_legal;
    assign accept_store = accept && (class_c == CLS_STORE);

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PRE_COMMIT:  if (sif_commit) phase_d = POST_COMMIT;
            POST_COMMIT: phase_d = POST_COMMIT;
            default:     phase_d = PRE_COMMIT;
        endcase
    end

    always_comb begin
        gap_d       = gap_q;
        violation_d = violation_q;
        bad_inst_d  = bad_inst_q;
        legal_cnt_d = legal_cnt_q;
        store_cnt_d = store_cnt_q;

        if (accept_store) begin
            gap_d = GAP_W'(STORE_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        if (accept && legal_cnt_q != '1) begin
            legal_cnt_d = legal_cnt_q + CNT_W'(1);
        end
        if (accept_store && store_cnt_q != '1) begin
            store_cnt_d = store_cnt_q + CNT_W'(1);
        end

        // Only the first offending word is kept; later rejects just keep the flag set.
        if (reject) begin
            violation_d = 1'b1;
            if (!violation_q) begin
                bad_inst_d = instruction;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= PRE_COMMIT;
            gap_q       <= '0;
            violation_q <= 1'b0;
            bad_inst_q  <= 32'd0;
            legal_cnt_q <= '0;
            store_cnt_q <= '0;
        end else begin
            phase_q     <= phase_d;
            gap_q       <= gap_d;
            violation_q <= violation_d;
            bad_inst_q  <= bad_inst_d;
            legal_cnt_q <= legal_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign phase     = (phase_q == POST_COMMIT);
    assign violation = violation_q;
    assign bad_inst  = bad_inst_q;
    assign legal_cnt = legal_cnt_q;
    assign store_cnt = store_cnt_q;

`ifdef QED_FORMAL_ASSUME_EN
    inst_legal_assume: assume property (
        @(posedge clk) disable iff (!rst_n) inst_valid |-> inst_legal
    );

    phase_rise_cover: cover property (
        @(posedge clk) disable iff (!rst_n) $rose(phase_q == POST_COMMIT)
    );
`else
    // Monitor-only build: legality is reported through violation and bad_inst.
`endif

endmodule

// File: tb/tb_qed_inst_filter.sv
// Directed self-checking bench for qed_inst_filter, built with STORE_GAP=2 and other defaults.
module tb_qed_inst_filter;

   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             instValid;
   logic [31:0]      instWord;
   logic             sifCommit;
   logic             instLegal;
   logic [3:0]       instClass;
   logic             phaseOut;
   logic             violationOut;
   logic [31:0]      badInst;
   logic [CNT_W-1:0] legalCnt;
   logic [CNT_W-1:0] storeCnt;

   int checkCount = 0;
   int errorCount = 0;

   localparam logic [31:0] ADD_OK   = 32'h003100B3;
   localparam logic [31:0] ADD_X16  = 32'h010100B3;
   localparam logic [31:0] JUNK_NOP = 32'h0000FFFF;
   localparam logic [31:0] SW_X1    = 32'h00102023;
   localparam logic [31:0] LW_IMM64 = 32'h04002083;
   localparam logic [31:0] LW_IMM63 = 32'h03F02083;
   localparam logic [31:0] JAL_X1   = 32'h000000EF;
   localparam logic [31:0] JAL_X0   = 32'h0000006F;
   localparam logic [31:0] NOP_WORD = 32'h0000007F;

   qed_inst_filter #(
      .REG_LIMIT   (16),
      .LD_IMM_LIMIT(64),
      .ST_IMM_LIMIT(2),
      .STORE_GAP   (2),
      .PC_DEP_EN   (0),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_valid (instValid),
      .instruction(instWord),
      .sif_commit (sifCommit),
      .inst_legal (instLegal),
      .inst_class (instClass),
      .phase      (phaseOut),
      .violation  (violationOut),
      .bad_inst   (badInst),
      .legal_cnt  (legalCnt),
      .store_cnt  (storeCnt)
   );

   // Free-running 10-unit clock; inputs change on the falling edge so the rising edge sees them stable.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch on one line.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Present one word on the falling edge and let the combinational decode settle.
   task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic commit);
      @(negedge clk);
      instValid = valid;
      instWord  = word;
      sifCommit = commit;
      #1;
   endtask

   // Step past the next rising edge so registered outputs can be sampled.
   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   // Every architectural output must be zero while reset is held.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_phase"}, {31'd0, phaseOut}, 32'd0);
      checkOutput({tag, "_violation"}, {31'd0, violationOut}, 32'd0);
      checkOutput({tag, "_bad_inst"}, badInst, 32'd0);
      checkOutput({tag, "_legal_cnt"}, {16'd0, legalCnt}, 32'd0);
      checkOutput({tag, "_store_cnt"}, {16'd0, storeCnt}, 32'd0);
   endtask

   // Directed sequence; every expected value below is worked out by hand from the decode rules.
   initial begin
      rst_n     = 1'b0;
      instValid = 1'b0;
      instWord  = 32'd0;
      sifCommit = 1'b0;
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, ADD_OK, 1'b0);
      checkOutput("add_legal", {31'd0, instLegal}, 32'd1);
      checkOutput("add_class", {28'd0, instClass}, 32'd1);
      nextEdge();
      checkOutput("add_legal_cnt", {16'd0, legalCnt}, 32'd1);
      checkOutput("add_no_violation", {31'd0, violationOut}, 32'd0);

      applyStimulus(1'b1, ADD_X16, 1'b0);
      checkOutput("x16_legal", {31'd0, instLegal}, 32'd0);
      checkOutput("x16_class", {28'd0, instClass}, 32'd1);
      nextEdge();
      checkOutput("x16_violation", {31'd0, violationOut}, 32'd1);
      checkOutput("x16_bad_inst", badInst, ADD_X16);
      checkOutput("x16_legal_cnt", {16'd0, legalCnt}, 32'd1);

      applyStimulus(1'b1, JUNK_NOP, 1'b0);
      checkOutput("junk_legal", {31'd0, instLegal}, 32'd0);
      nextEdge();
      checkOutput("junk_bad_inst_kept", badInst, ADD_X16);

      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("sw_precommit_legal", {31'd0, instLegal}, 32'd0);
      checkOutput("sw_class", {28'd0, instClass}, 32'd4);
      nextEdge();
      checkOutput("sw_precommit_phase", {31'd0, phaseOut}, 32'd0);
      checkOutput("sw_precommit_store_cnt", {16'd0, storeCnt}, 32'd0);

      applyStimulus(1'b1, SW_X1, 1'b1);
      checkOutput("sw_commit_legal", {31'd0, instLegal}, 32'd1);
      nextEdge();
      checkOutput("sw_commit_phase", {31'd0, phaseOut}, 32'd1);
      checkOutput("sw_commit_store_cnt", {16'd0, storeCnt}, 32'd1);
      checkOutput("sw_commit_legal_cnt", {16'd0, legalCnt}, 32'd2);

      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("gap_t1_legal", {31'd0, instLegal}, 32'd0);
      nextEdge();
      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("gap_t2_legal", {31'd0, instLegal}, 32'd0);
      nextEdge();
      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("gap_t3_legal", {31'd0, instLegal}, 32'd1);
      nextEdge();
      checkOutput("gap_store_cnt", {16'd0, storeCnt}, 32'd2);
      checkOutput("gap_legal_cnt", {16'd0, legalCnt}, 32'd3);
      checkOutput("gap_bad_inst_kept", badInst, ADD_X16);

      applyStimulus(1'b1, LW_IMM64, 1'b0);
      checkOutput("lw64_legal", {31'd0, instLegal}, 32'd0);
      nextEdge();
      applyStimulus(1'b1, LW_IMM63, 1'b0);
      checkOutput("lw63_legal", {31'd0, instLegal}, 32'd1);
      checkOutput("lw63_class", {28'd0, instClass}, 32'd3);
      nextEdge();
      checkOutput("lw63_legal_cnt", {16'd0, legalCnt}, 32'd4);

      applyStimulus(1'b1, JAL_X1, 1'b0);
      checkOutput("jal_x1_legal", {31'd0, instLegal}, 32'd0);
      checkOutput("jal_x1_class", {28'd0, instClass}, 32'd6);
      nextEdge();
      applyStimulus(1'b1, JAL_X0, 1'b0);
      checkOutput("jal_x0_legal", {31'd0, instLegal}, 32'd1);
      nextEdge();
      checkOutput("jal_x0_legal_cnt", {16'd0, legalCnt}, 32'd5);

      applyStimulus(1'b0, JAL_X0, 1'b0);
      nextEdge();
      checkOutput("invalid_no_count", {16'd0, legalCnt}, 32'd5);

      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("sw_postcommit_legal", {31'd0, instLegal}, 32'd1);
      nextEdge();
      checkOutput("sw_postcommit_store_cnt", {16'd0, storeCnt}, 32'd3);

      instValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, SW_X1, 1'b0);
      checkOutput("postreset_sw_blocked", {31'd0, instLegal}, 32'd0);
      nextEdge();
      checkOutput("postreset_violation", {31'd0, violationOut}, 32'd1);
      checkOutput("postreset_bad_inst", badInst, SW_X1);
      applyStimulus(1'b1, SW_X1, 1'b1);
      checkOutput("postreset_sw_commit", {31'd0, instLegal}, 32'd1);
      nextEdge();

      instValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b1, NOP_WORD, 1'b0);
      checkOutput("nop_legal", {31'd0, instLegal}, 32'd1);
      checkOutput("nop_class", {28'd0, instClass}, 32'd11);
      for (int i = 0; i < 65534; i++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("nop_cnt_fffe", {16'd0, legalCnt}, 32'h0000FFFE);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
      end
      #1;
      checkOutput("nop_cnt_saturated", {16'd0, legalCnt}, 32'h0000FFFF);
      checkOutput("nop_no_violation", {31'd0, violationOut}, 32'd0);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkAllZero("stream_reset");
      instValid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
